// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
//   state_t      : FSM encoding for the start/done handshake blocks
//   WIDTH_DEF    : default operand width
//   DIGIT_DEF    : default bits processed per clock
//   num_digits() : clock count per operation (WIDTH/DIGIT)
//   cnt_width()  : digit counter width, clog2(N) but never below 1
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DIGIT_DEF = 4;

    function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtractor: {bo, d} = a - b - bi.
//   a, b : DIGIT-bit operands
//   bi   : borrow in
//   d    : DIGIT-bit difference
//   bo   : borrow out (1 when a < b + bi)
module sub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    // One extra bit captures the wrap-around, which is exactly the borrow.
    logic [DIGIT:0] diff_ext;

    always_comb begin
        diff_ext = (DIGIT+1)'(a) - (DIGIT+1)'(b) - (DIGIT+1)'(bi);
        d        = diff_ext[DIGIT-1:0];
        bo       = diff_ext[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor32.sv
// Digit-serial two's-complement subtractor: D = A - B - Bi, borrow-out Bo.
// DIGIT bits per clock, borrow carried in a register between digits;
// done rises N = WIDTH/DIGIT edges after the accepting edge.
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   start      : request, honoured only in IDLE or DONE
//   A, B, Bi   : minuend, subtrahend, borrow-in; captured on accept
//   busy       : high while computing
//   done       : high while D/Bo hold a valid result
//   D, Bo      : difference mod 2^WIDTH, final borrow-out
module serial_subtractor32
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo
);

    localparam int unsigned N  = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    state_t           state_nxt;
    logic             accept_c;
    logic             last_c;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow_q;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bo;

    // Low digit of the operand shift registers, chained through borrow_q.
    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .a  (a_sr[DIGIT-1:0]),
        .b  (b_sr[DIGIT-1:0]),
        .bi (borrow_q),
        .d  (dig_d),
        .bo (dig_bo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge control strobes.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here.
                if (cnt == LAST) begin
                    last_c    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, digit shifting, result assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            borrow_q <= 1'b0;
            D        <= '0;
            Bo       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (accept_c) begin
            cnt      <= '0;
            a_sr     <= A;
            b_sr     <= B;
            borrow_q <= Bi;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (state == S_RUN) begin
            // Digits enter at the MSB end, so after N shifts the first one sits at bit 0.
            D        <= {dig_d, D[WIDTH-1:DIGIT]};
            a_sr     <= a_sr >> DIGIT;
            b_sr     <= b_sr >> DIGIT;
            borrow_q <= dig_bo;
            cnt      <= cnt + CW'(1);
            if (last_c) begin
                Bo   <= dig_bo;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed-vector bench for serial_subtractor32.
module tb_serial_subtractor32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bi;
    logic        busy;
    logic        done;
    logic [31:0] D;
    logic        Bo;

    int vectors;
    int miscompares;

    serial_subtractor32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bi    (Bi),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands and pulse start over exactly one rising edge (the accepting edge).
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic bi);
        @(negedge clk);
        A = a; B = b; Bi = bi; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges after the accepting edge until done; 99 means it never came.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (D !== 32'h0) begin miscompares++; $display("FAIL reset_D got=%h exp=00000000", D); end
        vectors++; if (Bo !== 1'b0) begin miscompares++; $display("FAIL reset_Bo got=%b exp=0", Bo); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL idle_hold busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_basic;
        int lat;
        pulse_start(32'd5, 32'd3, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got=%b exp=1", busy); end
        wait_done(lat);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        vectors++; if (D !== 32'h2) begin miscompares++; $display("FAIL basic_D got=%h exp=00000002", D); end
        vectors++; if (Bo !== 1'b0) begin miscompares++; $display("FAIL basic_Bo got=%b exp=0", Bo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_low got=%b exp=0", busy); end
        // Inputs wander while idle in DONE; the result must not move.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) A = 32'(i * 77); B = 32'(i + 1000);
            @(posedge clk);
            #1;
            vectors++; if (D !== 32'h2 || done !== 1'b1) begin
                miscompares++; $display("FAIL basic_hold[%0d] D=%h done=%b exp=00000002/1", i, D, done);
            end
        end
    endtask

    task automatic test_mixed;
        int lat;
        pulse_start(32'hFFC00FFC, 32'hFFFFF003, 1'b0);
        wait_done(lat);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL mixed1_latency got=%0d exp=8", lat); end
        vectors++; if (D !== 32'hFFC01FF9) begin miscompares++; $display("FAIL mixed1_D got=%h exp=ffc01ff9", D); end
        vectors++; if (Bo !== 1'b1) begin miscompares++; $display("FAIL mixed1_Bo got=%b exp=1", Bo); end
        pulse_start(32'd10, 32'd3, 1'b1);
        wait_done(lat);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL mixed2_latency got=%0d exp=8", lat); end
        vectors++; if (D !== 32'h6) begin miscompares++; $display("FAIL mixed2_D got=%h exp=00000006", D); end
        vectors++; if (Bo !== 1'b0) begin miscompares++; $display("FAIL mixed2_Bo got=%b exp=0", Bo); end
    endtask

    task automatic test_boundary;
        int lat;
        pulse_start(32'h0, 32'h0, 1'b1);
        wait_done(lat);
        vectors++; if (D !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL zero_borrow_D got=%h exp=ffffffff", D); end
        vectors++; if (Bo !== 1'b1) begin miscompares++; $display("FAIL zero_borrow_Bo got=%b exp=1", Bo); end
        pulse_start(32'h80000000, 32'h80000000, 1'b0);
        wait_done(lat);
        vectors++; if (D !== 32'h0) begin miscompares++; $display("FAIL equal_D got=%h exp=00000000", D); end
        vectors++; if (Bo !== 1'b0) begin miscompares++; $display("FAIL equal_Bo got=%b exp=0", Bo); end
    endtask

    task automatic test_busy_ignore;
        int lat;
        pulse_start(32'd100, 32'd1, 1'b0);
        @(posedge clk);                       // RUN edge 1
        @(negedge clk);                       // start + new operands across RUN edge 3
        @(negedge clk) A = 32'd7; B = 32'd9; Bi = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ignore_busy got=%b exp=1", busy); end
        wait_done(lat);
        // Three RUN edges already passed, so done after five more.
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
        vectors++; if (D !== 32'd99) begin miscompares++; $display("FAIL ignore_D got=%h exp=00000063", D); end
        vectors++; if (Bo !== 1'b0) begin miscompares++; $display("FAIL ignore_Bo got=%b exp=0", Bo); end
        // Back-to-back from DONE.
        pulse_start(32'd1, 32'd2, 1'b0);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
        wait_done(lat);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
        vectors++; if (D !== 32'hFFFFFFFF || Bo !== 1'b1) begin
            miscompares++; $display("FAIL b2b_result D=%h Bo=%b exp=ffffffff/1", D, Bo);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        bit saw_done;
        pulse_start(32'd50, 32'd20, 1'b0);
        repeat (3) @(posedge clk);            // RUN edges 1..3
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);                       // RUN edge 4 under reset
        #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || D !== 32'h0 || Bo !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs busy=%b done=%b D=%h Bo=%b exp=0/0/00000000/0", busy, done, D, Bo);
        end
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got=1 exp=0"); end
        pulse_start(32'd50, 32'd20, 1'b0);
        wait_done(lat);
        vectors++; if (lat !== 8) begin miscompares++; $display("FAIL abort_restart_latency got=%0d exp=8", lat); end
        vectors++; if (D !== 32'd30 || Bo !== 1'b0) begin
            miscompares++; $display("FAIL abort_restart D=%h Bo=%b exp=0000001e/0", D, Bo);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_basic;
        test_mixed;
        test_boundary;
        test_busy_ignore;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
